// File: rtl/dmux_slow2fast.sv
// Slow-to-fast DMUX crossing: only the valid level is synchronized into clk_b, and the data
// word is captured on the rising edge of the synchronized valid.
module dmux_slow2fast #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_b,
    input  logic              rst_n,
    input  logic              clk_a,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_in_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_valid
);

    // The source clock is kept on the port list for drop-in compatibility only.
    logic unused_clk_a;
    assign unused_clk_a = clk_a;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;
    logic                   rise;

    assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;

    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], data_in_valid};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    // data_in is only sampled once the synchronized valid says it has settled.
    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else begin
            data_out_valid <= rise;
            if (rise) begin
                data_out <= data_in;
            end
        end
    end

endmodule

// File: tb/tb_dmux_slow2fast.sv
// Self-checking bench for dmux_slow2fast: directed scenarios plus randomized word traffic,
// all compared against a sample-history model of the valid-to-pulse relationship.
module tb_dmux_slow2fast;

    localparam int unsigned W = 8;
    localparam int unsigned S = 2;

    logic         clk_b = 1'b0;
    logic         clk_a = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         data_in_valid = 1'b0;
    logic [W-1:0] data_out;
    logic         data_out_valid;

    int total = 0;
    int bad   = 0;

    always #10 clk_b = ~clk_b;
    always #20 clk_a = ~clk_a;

    dmux_slow2fast #(.DATA_W(W), .SYNC_STAGES(S)) dut (
        .clk_b          (clk_b),
        .rst_n          (rst_n),
        .clk_a          (clk_a),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_out       (data_out),
        .data_out_valid (data_out_valid)
    );

    // Model: remembers what valid looked like at each past clk_b edge. A pulse follows edge n
    // when valid was sampled high at edge n-S and low at edge n-S-1; the word is data_in at n.
    bit           samples [0:S];
    logic         exp_valid = 1'b0;
    logic [W-1:0] exp_data  = '0;

    always @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= S; i++) samples[i] <= 1'b0;
            exp_valid <= 1'b0;
            exp_data  <= '0;
        end else begin
            exp_valid <= samples[S-1] && !samples[S];
            if (samples[S-1] && !samples[S]) exp_data <= data_in;
            samples[0] <= data_in_valid;
            for (int i = 1; i <= S; i++) samples[i] <= samples[i-1];
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        data_in = 8'hFF;
        data_in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_b);
            total++;
            if (data_out !== 8'h00 || data_out_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset cyc%0d: data_out=%h valid=%b, want 00/0", k, data_out,
                         data_out_valid);
            end
        end
        data_in_valid = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) @(negedge clk_b);
    endtask

    task automatic test_basic();
        data_in = 8'd54;
        data_in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_b);
            total++;
            if (data_out_valid !== (k == 2) ||
                data_out !== ((k >= 2) ? 8'd54 : 8'd0)) begin
                bad++;
                $display("FAIL basic after E%0d: valid=%b data=%0d, want %b/%0d", k,
                         data_out_valid, data_out, (k == 2), ((k >= 2) ? 54 : 0));
            end
            if (k == 1) data_in_valid = 1'b0;
        end
    endtask

    task automatic test_long_valid();
        int pulses = 0;
        data_in = 8'hA5;
        data_in_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk_b);
            if (data_out_valid === 1'b1) pulses++;
            total++;
            if (data_out_valid !== exp_valid || data_out !== exp_data) begin
                bad++;
                $display("FAIL long cyc%0d: got %b/%h, want %b/%h", k, data_out_valid,
                         data_out, exp_valid, exp_data);
            end
            if (k == 9) data_in_valid = 1'b0;
        end
        total++;
        if (pulses != 1 || data_out !== 8'hA5) begin
            bad++;
            $display("FAIL long summary: pulses=%0d data=%h, want 1/a5", pulses, data_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words [$];
        logic [W-1:0] src [2];
        src[0] = 8'h11;
        src[1] = 8'h22;
        for (int w = 0; w < 2; w++) begin
            data_in = src[w];
            data_in_valid = 1'b1;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk_b);
                if (data_out_valid === 1'b1) words.push_back(data_out);
                if (k == 1) data_in_valid = 1'b0;
            end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_b);
            if (data_out_valid === 1'b1) words.push_back(data_out);
        end
        total++;
        if (words.size() != 2) begin
            bad++;
            $display("FAIL b2b count: got %0d pulses, want 2", words.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                total++;
                if (words[i] !== src[i]) begin
                    bad++;
                    $display("FAIL b2b word%0d: got %h, want %h", i, words[i], src[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        data_in = 8'h77;
        data_in_valid = 1'b1;
        @(negedge clk_b);
        rst_n = 1'b0;
        #1;
        total++;
        if (data_out !== 8'h00 || data_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rstmid async: got %b/%h, want 0/00", data_out_valid, data_out);
        end
        @(negedge clk_b);
        data_in_valid = 1'b0;
        @(negedge clk_b);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_b);
            if (data_out_valid === 1'b1) pulses++;
        end
        total++;
        if (pulses != 0 || data_out !== 8'h00) begin
            bad++;
            $display("FAIL rstmid: pulses=%0d data=%h, want 0/00", pulses, data_out);
        end
    endtask

    task automatic test_idle_toggle();
        logic [W-1:0] held;
        held = data_out;
        data_in_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            data_in = W'($urandom);
            @(negedge clk_b);
            total++;
            if (data_out !== held || data_out_valid !== 1'b0) begin
                bad++;
                $display("FAIL idle cyc%0d: got %b/%h, want 0/%h", k, data_out_valid,
                         data_out, held);
            end
        end
    endtask

    task automatic test_random();
        int exp_pulses = 0;
        int got_pulses = 0;
        for (int w = 0; w < 30; w++) begin
            int hi = $urandom_range(2, 8);
            int lo = $urandom_range(3, 6);
            data_in = W'($urandom);
            data_in_valid = 1'b1;
            exp_pulses++;
            for (int k = 0; k < hi + lo; k++) begin
                @(negedge clk_b);
                if (data_out_valid === 1'b1) got_pulses++;
                total++;
                if (data_out_valid !== exp_valid || data_out !== exp_data) begin
                    bad++;
                    $display("FAIL random w%0d cyc%0d: got %b/%h, want %b/%h", w, k,
                             data_out_valid, data_out, exp_valid, exp_data);
                end
                if (k == hi - 1) data_in_valid = 1'b0;
                if (k > S && k >= hi) data_in = W'($urandom);
            end
        end
        total++;
        if (got_pulses != exp_pulses) begin
            bad++;
            $display("FAIL random count: got %0d, want %0d", got_pulses, exp_pulses);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_long_valid();
        test_back_to_back();
        test_idle_toggle();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
